// File: rtl/inst_execute_pkg.sv
// inst_execute_pkg: RV64I encodings shared by decode, execute and memory.
// Holds opcode/funct3 constants and the forwarding match helper.
package inst_execute_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 bit selecting SUB/SRA; immediate bit selecting SRAI
    localparam int F7_ALT_BIT  = 5;
    localparam int SRA_IMM_BIT = 10;

    // A producer forwards only when enabled, not x0, and indices match
    function automatic logic fwd_match(
        input logic       en,
        input logic [4:0] src_rd,
        input logic [4:0] rs
    );
        return en && (src_rd != 5'd0) && (src_rd == rs);
    endfunction

endpackage

// File: rtl/inst_execute_alu.sv
// alu_rv64: combinational RV64I OP/OP-IMM datapath.
// Selects the operation from funct3 with funct7/imm variants for SUB/SRA.
module alu_rv64
    import inst_execute_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            imm_flag,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] result
);

    localparam int SHW = (XLEN == 64) ? 6 : 5;

    logic [SHW-1:0] shamt;
    logic           alt_sub;
    logic           alt_sra;
    logic           lt_s;
    logic           lt_u;
    logic           unused_funct7;

    assign shamt   = src2[SHW-1:0];
    assign alt_sub = !imm_flag && funct7[F7_ALT_BIT];
    assign alt_sra = imm_flag ? src2[SRA_IMM_BIT] : funct7[F7_ALT_BIT];
    assign lt_s    = $signed(src1) < $signed(src2);
    assign lt_u    = src1 < src2;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Operation select
    always_comb begin
        result = '0;
        unique case (funct3)
            F3_ADD:  result = alt_sub ? (src1 - src2) : (src1 + src2);
            F3_SLL:  result = src1 << shamt;
            F3_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            F3_XOR:  result = src1 ^ src2;
            F3_SR:   result = alt_sra ? XLEN'($signed(src1) >>> shamt)
                                      : (src1 >> shamt);
            F3_OR:   result = src1 | src2;
            F3_AND:  result = src1 & src2;
        endcase
    end

endmodule

// File: rtl/inst_execute.sv
// inst_execute: RV64I execute stage with EX/MEM forwarding.
// Captures results into EX/MEM, turns stalls into bubbles, counts both.
module inst_execute
    import inst_execute_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic             write_back,
    input  logic             imm_flag,
    input  logic             mem_acc,
    input  logic             load_flag,
    input  logic             stall_raise,
    input  logic [4:0]       mem_rd,
    input  logic [XLEN-1:0]  mem_value,
    input  logic             mem_fwd_en,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic [XLEN-1:0]  ex_result,
    output logic             ex_write_back,
    output logic             ex_mem_acc,
    output logic             ex_load_flag,
    output logic             ex_valid,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] alu_out;
    logic            ex_fwd_en;
    logic            ex_hit1;
    logic            ex_hit2;
    logic            mem_hit1;
    logic            mem_hit2;

    // A load in EX has no data yet; its consumer waits for the MEM path
    assign ex_fwd_en = ex_valid && ex_write_back && !ex_load_flag;

    assign ex_hit1  = fwd_match(ex_fwd_en, ex_rd, rs1);
    assign ex_hit2  = fwd_match(ex_fwd_en, ex_rd, rs2);
    assign mem_hit1 = fwd_match(mem_fwd_en, mem_rd, rs1);
    assign mem_hit2 = fwd_match(mem_fwd_en, mem_rd, rs2);

    // src1 bypass: younger EX result beats MEM value
    always_comb begin
        src1 = op1;
        if (ex_hit1) begin
            src1 = ex_result;
        end else if (mem_hit1) begin
            src1 = mem_value;
        end
    end

    // src2 bypass: immediates are never replaced
    always_comb begin
        src2 = op2;
        if (!imm_flag) begin
            if (ex_hit2) begin
                src2 = ex_result;
            end else if (mem_hit2) begin
                src2 = mem_value;
            end
        end
    end

    alu_rv64 #(
        .XLEN(XLEN)
    ) u_alu (
        .funct3  (funct3),
        .funct7  (funct7),
        .imm_flag(imm_flag),
        .src1    (src1),
        .src2    (src2),
        .result  (alu_out)
    );

    // EX/MEM pipeline register; a stall captures an all-zero bubble
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_funct3     <= '0;
            ex_result     <= '0;
            ex_write_back <= 1'b0;
            ex_mem_acc    <= 1'b0;
            ex_load_flag  <= 1'b0;
        end else if (stall_raise) begin
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_funct3     <= '0;
            ex_result     <= '0;
            ex_write_back <= 1'b0;
            ex_mem_acc    <= 1'b0;
            ex_load_flag  <= 1'b0;
        end else begin
            ex_valid      <= 1'b1;
            ex_rd         <= rd;
            ex_funct3     <= funct3;
            ex_result     <= alu_out;
            ex_write_back <= write_back;
            ex_mem_acc    <= mem_acc;
            ex_load_flag  <= load_flag;
        end
    end

    // Occupancy counters, wrapping at 2^CNT_W
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            issued_cnt <= '0;
            bubble_cnt <= '0;
        end else if (stall_raise) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else begin
            issued_cnt <= issued_cnt + CNT_W'(1);
        end
    end

endmodule
